// File: rtl/store_narrow_unit.sv
// Store narrowing unit: narrows a 32-bit value to byte/half/word and writes it big-endian,
// one byte per accepted memory cycle. Optional truncation check enabled by STORE_TRUNC_CHECK_EN.
module store_narrow_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [31:0]       st_data,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [1:0]        st_size,
    output logic              st_done,
    output logic              st_err,
    output logic              trunc_ovf,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic              mem_ready
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WRITE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    logic [1:0]        state;
    logic [1:0]        byte_idx;
    logic [1:0]        last_idx;
    logic [ADDR_W-1:0] base_addr;
    logic [31:0]       shift_data;
    logic              err_pulse;

    logic              accept;
    logic              req_ok;
    logic [31:0]       aligned_data;
    logic [1:0]        req_last_idx;

    assign accept = st_valid && st_ready;

    // The kept bytes are left-justified so the next byte to send is always shift_data[31:24].
    always_comb begin
        req_ok       = 1'b0;
        aligned_data = st_data;
        req_last_idx = 2'd0;
        case (st_size)
            SZ_BYTE: begin
                req_ok       = 1'b1;
                aligned_data = {st_data[7:0], 24'h0};
                req_last_idx = 2'd0;
            end
            SZ_HALF: begin
                req_ok       = !st_addr[0];
                aligned_data = {st_data[15:0], 16'h0};
                req_last_idx = 2'd1;
            end
            SZ_WORD: begin
                req_ok       = (st_addr[1:0] == 2'b00);
                aligned_data = st_data;
                req_last_idx = 2'd3;
            end
            default: begin
                req_ok       = 1'b0;
                aligned_data = st_data;
                req_last_idx = 2'd0;
            end
        endcase
    end

`ifdef STORE_TRUNC_CHECK_EN
    logic ovf_next;
    logic ovf_q;

    always_comb begin
        ovf_next = 1'b0;
        case (st_size)
            SZ_BYTE: ovf_next = (st_data[31:8]  != {24{st_data[7]}});
            SZ_HALF: ovf_next = (st_data[31:16] != {16{st_data[15]}});
            default: ovf_next = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (state == S_IDLE && accept && req_ok) begin
            ovf_q <= ovf_next;
        end
    end

    assign trunc_ovf = (state == S_DONE) && ovf_q;
`else
    assign trunc_ovf = 1'b0;
`endif

    // Main sequencer; data only shifts on an accepted byte so outputs hold during stalls.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            byte_idx   <= 2'd0;
            last_idx   <= 2'd0;
            base_addr  <= '0;
            shift_data <= 32'h0;
            err_pulse  <= 1'b0;
        end else begin
            err_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (req_ok) begin
                            base_addr  <= st_addr;
                            shift_data <= aligned_data;
                            last_idx   <= req_last_idx;
                            byte_idx   <= 2'd0;
                            state      <= S_WRITE;
                        end else begin
                            err_pulse <= 1'b1;
                        end
                    end
                end
                S_WRITE: begin
                    if (mem_ready) begin
                        shift_data <= {shift_data[23:0], 8'h0};
                        byte_idx   <= byte_idx + 2'd1;
                        if (byte_idx == last_idx) begin
                            state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign st_ready  = (state == S_IDLE) && !reset;
    assign st_done   = (state == S_DONE);
    assign st_err    = err_pulse;
    assign mem_we    = (state == S_WRITE);
    assign mem_addr  = mem_we ? (base_addr + ADDR_W'(byte_idx)) : '0;
    assign mem_wdata = mem_we ? shift_data[31:24] : 8'h0;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed and random stores checked by a queue-based scoreboard.
// Truncation expectations follow STORE_TRUNC_CHECK_EN when defined.
module tb_store_narrow_unit;

    localparam int ADDR_W = 32;
    localparam int K_WRITE = 0;
    localparam int K_DONE  = 1;
    localparam int K_ERR   = 2;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [7:0]  data;
        logic        trunc;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              st_valid = 1'b0;
    logic              st_ready;
    logic [31:0]       st_data = 32'h0;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [1:0]        st_size = 2'b00;
    logic              st_done;
    logic              st_err;
    logic              trunc_ovf;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_ready = 1'b0;

    exp_t exp_q[$];
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    int          ready_mode = 1;
    logic [31:0] stall_addr = 32'h0;
    int          stall_cnt  = 0;
    int          held_cnt   = 0;

    logic        stall_prev  = 1'b0;
    logic [31:0] prev_addr   = 32'h0;
    logic [7:0]  prev_data   = 8'h0;
    logic        last_accept = 1'b0;

    store_narrow_unit #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_data   (st_data),
        .st_addr   (st_addr),
        .st_size   (st_size),
        .st_done   (st_done),
        .st_err    (st_err),
        .trunc_ovf (trunc_ovf),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %h, want %h at %0t", name, actual, expected, $time);
        end else begin
            passes++;
        end
    endtask

    // Reference: a store of value v keeps the low N bytes; it is lossy when v as a signed
    // number falls outside the range representable in N bytes.
    function automatic logic model_trunc(input logic [1:0] size, input logic [31:0] v);
`ifdef STORE_TRUNC_CHECK_EN
        int signed sv;
        sv = $signed(v);
        if (size == 2'b00) return (sv < -128) || (sv > 127);
        if (size == 2'b01) return (sv < -32768) || (sv > 32767);
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_push(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] v);
        int   nbytes;
        exp_t e;
        nbytes = (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
        if (size == 2'b11 || (addr % nbytes) != 0) begin
            e = '{kind: K_ERR, addr: 32'h0, data: 8'h0, trunc: 1'b0};
            exp_q.push_back(e);
            return;
        end
        for (int k = 0; k < nbytes; k++) begin
            e.kind  = K_WRITE;
            e.addr  = addr + k;
            e.data  = 8'((v >> (8 * (nbytes - 1 - k))) & 32'hFF);
            e.trunc = 1'b0;
            exp_q.push_back(e);
        end
        e = '{kind: K_DONE, addr: 32'h0, data: 8'h0, trunc: model_trunc(size, v)};
        exp_q.push_back(e);
    endtask

    // Issues one request at the first IDLE negedge; the handshake lands on the following posedge.
    task automatic applyStimulus(input logic [1:0] size, input logic [31:0] addr, input logic [31:0] v);
        int budget;
        budget = 0;
        @(negedge clk);
        while (!st_ready && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        if (!st_ready) begin
            checkOutput("ready_timeout", 32'(st_ready), 32'h1);
            return;
        end
        st_valid = 1'b1;
        st_size  = size;
        st_addr  = addr;
        st_data  = v;
        model_push(size, addr, v);
        @(posedge clk);
        #1;
        st_valid = 1'b0;
        st_data  = $urandom;
        st_addr  = $urandom;
        st_size  = 2'($urandom_range(0, 3));
    endtask

    // Called right after applyStimulus; returns the cycle index of st_done/st_err (handshake = 0).
    task automatic wait_complete(output int cyc);
        cyc = 1;
        forever begin
            @(negedge clk);
            if (st_done || st_err || cyc > 300) break;
            @(posedge clk);
            cyc++;
        end
        if (cyc > 300) checkOutput("complete_timeout", 32'h0, 32'h1);
    endtask

    // Memory model: ready decided just after each rising edge from the current request.
    always @(posedge clk) begin
        #1;
        if (ready_mode == 0) begin
            mem_ready = ($urandom_range(0, 3) != 0);
        end else if (ready_mode == 2 && mem_we && mem_addr == stall_addr && stall_cnt > 0) begin
            mem_ready = 1'b0;
            stall_cnt--;
        end else begin
            mem_ready = 1'b1;
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents a byte, completion or error.
    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            stall_prev  = 1'b0;
            last_accept = 1'b0;
        end else begin
            if (stall_prev) begin
                checkOutput("hold_we", 32'(mem_we), 32'h1);
                checkOutput("hold_addr", mem_addr, prev_addr);
                checkOutput("hold_wdata", 32'(mem_wdata), 32'(prev_data));
            end
            if (mem_we && mem_addr == 32'h101) held_cnt++;
            if (mem_we && mem_ready) begin
                checkOutput("q_write_nonempty", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("write_kind", 32'(K_WRITE), 32'(e.kind));
                    checkOutput("write_addr", mem_addr, e.addr);
                    checkOutput("write_data", 32'(mem_wdata), 32'(e.data));
                end
            end
            if (st_done) begin
                checkOutput("done_after_accept", 32'(last_accept), 32'h1);
                checkOutput("q_done_nonempty", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("done_kind", 32'(K_DONE), 32'(e.kind));
                    checkOutput("trunc_ovf", 32'(trunc_ovf), 32'(e.trunc));
                end
            end else if (trunc_ovf) begin
                checkOutput("trunc_outside_done", 32'(trunc_ovf), 32'h0);
            end
            if (st_err) begin
                checkOutput("q_err_nonempty", 32'(exp_q.size() != 0), 32'h1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    checkOutput("err_kind", 32'(K_ERR), 32'(e.kind));
                end
            end
            stall_prev  = mem_we && !mem_ready;
            prev_addr   = mem_addr;
            prev_data   = mem_wdata;
            last_accept = mem_we && mem_ready;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running, want finished");
        $fatal(1, "[TB] global timeout");
    end

    initial begin
        int cyc;
        int budget;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] v;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(st_ready), 32'h0);
        checkOutput("rst_we", 32'(mem_we), 32'h0);
        checkOutput("rst_done", 32'(st_done), 32'h0);
        checkOutput("rst_err", 32'(st_err), 32'h0);
        checkOutput("rst_trunc", 32'(trunc_ovf), 32'h0);
        checkOutput("rst_addr", mem_addr, 32'h0);
        checkOutput("rst_wdata", 32'(mem_wdata), 32'h0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", 32'(st_ready), 32'h1);

        ready_mode = 1;
        applyStimulus(2'b10, 32'h100, 32'hDEADBEEF);
        wait_complete(cyc);
        checkOutput("word_latency", 32'(cyc), 32'd5);
        checkOutput("done_not_ready", 32'(st_ready), 32'h0);
        @(negedge clk);
        checkOutput("ready_after_done", 32'(st_ready), 32'h1);

        applyStimulus(2'b01, 32'h202, 32'hFFFF8001);
        wait_complete(cyc);
        checkOutput("half_latency", 32'(cyc), 32'd3);
        applyStimulus(2'b01, 32'h202, 32'h00018001);
        wait_complete(cyc);
        applyStimulus(2'b00, 32'h3, 32'h0000007F);
        wait_complete(cyc);
        checkOutput("byte_latency", 32'(cyc), 32'd2);
        applyStimulus(2'b00, 32'h3, 32'h00000080);
        wait_complete(cyc);

        applyStimulus(2'b10, 32'h102, 32'h12345678);
        wait_complete(cyc);
        checkOutput("misaligned_err_cycle", 32'(cyc), 32'd1);
        checkOutput("misaligned_ready", 32'(st_ready), 32'h1);
        applyStimulus(2'b11, 32'h100, 32'h12345678);
        wait_complete(cyc);
        checkOutput("illegal_err_cycle", 32'(cyc), 32'd1);
        checkOutput("illegal_ready", 32'(st_ready), 32'h1);

        ready_mode = 2;
        stall_addr = 32'h101;
        stall_cnt  = 3;
        held_cnt   = 0;
        applyStimulus(2'b10, 32'h100, 32'hDEADBEEF);
        wait_complete(cyc);
        checkOutput("stall_latency", 32'(cyc), 32'd8);
        checkOutput("stall_held_cycles", 32'(held_cnt), 32'd4);
        ready_mode = 1;

        applyStimulus(2'b10, 32'h400, 32'hAABBCCDD);
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(mem_we && mem_addr == 32'h402) && budget < 50);
        checkOutput("reach_k2", 32'(mem_we && mem_addr == 32'h402), 32'h1);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_we", 32'(mem_we), 32'h0);
        checkOutput("abort_done", 32'(st_done), 32'h0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        checkOutput("abort_idle_ready", 32'(st_ready), 32'h1);
        checkOutput("abort_no_done", 32'(st_done), 32'h0);
        applyStimulus(2'b00, 32'h55, 32'h000000A5);
        wait_complete(cyc);
        checkOutput("post_abort_byte_latency", 32'(cyc), 32'd2);

        ready_mode = 0;
        for (int i = 0; i < 300; i++) begin
            size = 2'($urandom_range(0, 3));
            addr = $urandom;
            if ($urandom_range(0, 3) != 0) addr[1:0] = 2'b00;
            if ($urandom_range(0, 7) == 0) addr = 32'hFFFF_FFFC;
            v = $urandom;
            case ($urandom_range(0, 2))
                1: v = {{24{v[7]}}, v[7:0]};
                2: v = {{16{v[15]}}, v[15:0]};
                default: ;
            endcase
            applyStimulus(size, addr, v);
        end

        budget = 0;
        while (exp_q.size() != 0 && budget < 1000) begin
            @(negedge clk);
            budget++;
        end
        checkOutput("drain", 32'(exp_q.size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
